// File: rtl/key_scan_if.sv
// Keypad-side bundle for key_scan_ctrl: enable and raw rows in, column drive and
// debounced key event out. master = scan controller, slave = keypad/decoder side.
interface key_scan_if;
    logic       scan_en;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [7:0] key_code_raw;
    logic       key_held;

    modport master (
        input  scan_en,
        input  row_in,
        output col_out,
        output key_valid,
        output key_code_raw,
        output key_held
    );

    modport slave (
        output scan_en,
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code_raw,
        input  key_held
    );
endinterface

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: walks active-low columns, debounces press and release on the
// synchronized rows, and emits one key_valid pulse per accepted press.
module key_scan_ctrl #(
    parameter int SCAN_CYCLES     = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk_27mhz,
    input  logic       reset_n,
    key_scan_if.master kif
);
    localparam int DWELL_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SCAN         = 3'd1,
        DEBOUNCE     = 3'd2,
        PRESS        = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         row_meta_p0;
    logic [3:0]         row_sync_p1;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DEB_W-1:0]   stable_cnt;
    logic [1:0]         col_idx;
    logic [7:0]         cand_code;
    logic [3:0]         col_drive;
    logic               key_valid_r;
    logic [7:0]         key_code_r;
    logic               key_held_r;
    logic               single_row;
    logic               rows_idle;
    logic               cand_match;
    logic               dwell_done;
    logic               stable_done;

    // Exactly one row low; anything else is either no key or a ghosting pattern.
    always_comb begin
        single_row = 1'b0;
        case (row_sync_p1)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_row = 1'b1;
            default:                            single_row = 1'b0;
        endcase
    end

    assign rows_idle   = (row_sync_p1 == 4'b1111);
    assign cand_match  = (row_sync_p1 == cand_code[3:0]);
    assign dwell_done  = (dwell_cnt == DWELL_LAST);
    assign stable_done = (stable_cnt == DEB_LAST);

    // Stage p0 -> p1: two-flop synchronizer for the asynchronous row pins
    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_p0 <= 4'b1111;
            row_sync_p1 <= 4'b1111;
        end else begin
            row_meta_p0 <= kif.row_in;
            row_sync_p1 <= row_meta_p0;
        end
    end

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!kif.scan_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:         next_state = SCAN;
                SCAN:         if (dwell_done && single_row) next_state = DEBOUNCE;
                DEBOUNCE: begin
                    if (!cand_match)      next_state = SCAN;
                    else if (stable_done) next_state = PRESS;
                end
                PRESS:        next_state = WAIT_RELEASE;
                WAIT_RELEASE: if (rows_idle && stable_done) next_state = SCAN;
                default:      next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        col_drive = 4'b1111;
        if (state != IDLE) col_drive = ~(4'b0001 << col_idx);
    end

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            dwell_cnt   <= '0;
            stable_cnt  <= '0;
            col_idx     <= 2'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 8'h00;
            key_held_r  <= 1'b0;
        end else begin
            // Outputs are registered off next_state so they appear in the PRESS cycle itself.
            key_valid_r <= (next_state == PRESS);
            if (next_state == PRESS) key_code_r <= cand_code;
            if (next_state == PRESS)
                key_held_r <= 1'b1;
            else if ((next_state == IDLE) || ((state == WAIT_RELEASE) && (next_state == SCAN)))
                key_held_r <= 1'b0;

            if (!kif.scan_en) begin
                dwell_cnt  <= '0;
                stable_cnt <= '0;
                col_idx    <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        dwell_cnt  <= '0;
                        stable_cnt <= '0;
                        col_idx    <= 2'd0;
                    end
                    SCAN: begin
                        if (dwell_done) begin
                            dwell_cnt  <= '0;
                            stable_cnt <= '0;
                            if (!single_row) col_idx <= col_idx + 2'd1;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!cand_match || stable_done) stable_cnt <= '0;
                        else                            stable_cnt <= stable_cnt + 1'b1;
                    end
                    PRESS: stable_cnt <= '0;
                    WAIT_RELEASE: begin
                        if (!rows_idle) begin
                            stable_cnt <= '0;
                        end else if (stable_done) begin
                            stable_cnt <= '0;
                            col_idx    <= col_idx + 2'd1;
                        end else begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end
                    end
                    default: begin
                        dwell_cnt  <= '0;
                        stable_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Candidate code is pure data and is always written before it is read.
    always_ff @(posedge clk_27mhz) begin
        if ((state == SCAN) && dwell_done && single_row)
            cand_code <= {col_drive, row_sync_p1};
    end

    assign kif.col_out      = col_drive;
    assign kif.key_valid    = key_valid_r;
    assign kif.key_code_raw = key_code_r;
    assign kif.key_held     = key_held_r;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: a keypad matrix model reacts to col_out, and a timeline
// model (scan origin + key windows) predicts every output on every cycle.
module tb_key_scan_ctrl;
    localparam int S = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    key_scan_if kif();

    key_scan_ctrl #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk_27mhz(clk),
        .reset_n  (reset_n),
        .kif      (kif)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit scanning = 1'b0;
    bit tracking = 1'b0;
    bit free_run = 1'b0;
    bit manual   = 1'b0;
    int t0 = 0, c0 = 0, kr = 0, kc = 0;
    int w_start = -1, pulse_at = -1, restart_at = -1, enable_at = -1, disable_at = -1;
    logic [7:0] exp_code = 8'h00;
    logic       exp_held = 1'b0;
    logic [3:0] keys [4];

    function automatic logic [3:0] onecold(input int idx);
        logic [3:0] m;
        m = 4'b0001 << idx;
        return ~m;
    endfunction

    // Physical keypad: a pressed key pulls its row low only while its column is driven.
    function automatic logic [3:0] keypad();
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!kif.col_out[c]) r = r & ~keys[c];
        return r;
    endfunction

    // First window start for column kc at or after cycle 'from', on the current scan timeline.
    function automatic int next_window(input int from);
        int k;
        k = 0;
        if (from > t0) k = (from - t0 + S - 1) / S;
        while (((c0 + k) % 4) != kc) k++;
        return t0 + k * S;
    endfunction

    function automatic logic [3:0] col_model(input int n);
        if (!scanning) return 4'hF;
        if (w_start >= 0 && n >= w_start) return onecold(kc);
        return onecold((c0 + (n - t0) / S) % 4);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},  8'(kif.col_out),      8'h0F);
        check({tag, "_kv"},   8'(kif.key_valid),    8'h00);
        check({tag, "_code"}, kif.key_code_raw,     8'h00);
        check({tag, "_held"}, 8'(kif.key_held),     8'h00);
    endtask

    task automatic step();
        logic ev;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == disable_at) begin
            scanning = 1'b0; w_start = -1; pulse_at = -1; restart_at = -1;
            exp_held = 1'b0; disable_at = -1;
        end
        if (cyc == enable_at) begin
            scanning = 1'b1; t0 = cyc; c0 = 0; enable_at = -1;
            if (tracking) begin
                w_start  = next_window(cyc);
                pulse_at = w_start + S + D;
            end
        end
        if (cyc == restart_at) begin
            t0 = cyc; c0 = (kc + 1) % 4; exp_held = 1'b0;
            w_start = -1; pulse_at = -1; restart_at = -1; tracking = 1'b0;
        end
        ev = (cyc == pulse_at);
        if (ev) begin
            exp_code = {onecold(kc), onecold(kr)};
            exp_held = 1'b1;
        end
        if (!free_run) begin
            check("col_out",      8'(kif.col_out),   8'(col_model(cyc)));
            check("key_valid",    8'(kif.key_valid), 8'(ev));
            check("key_held",     8'(kif.key_held),  8'(exp_held));
            check("key_code_raw", kif.key_code_raw,  exp_code);
        end
        if (!manual) kif.row_in = keypad();
    endtask

    task automatic press_when_safe(input int r, input int c);
        while (col_model(cyc) == onecold(c)) step();
        keys[c][r] = 1'b1;
        kr = r; kc = c; tracking = 1'b1;
        w_start  = next_window(cyc + 1);
        pulse_at = w_start + S + D;
        kif.row_in = keypad();
    endtask

    task automatic release_keys();
        for (int c = 0; c < 4; c++) keys[c] = 4'h0;
        restart_at = tracking ? cyc + D + 2 : -1;
        kif.row_in = keypad();
    endtask

    task automatic do_key(input int r, input int c, input int hold);
        int rs;
        press_when_safe(r, c);
        while (cyc < pulse_at + hold) step();
        release_keys();
        rs = restart_at;
        while (cyc < rs + 3) step();
    endtask

    task automatic hit_reset(input string tag);
        reset_n = 1'b0;
        scanning = 1'b0; w_start = -1; pulse_at = -1; restart_at = -1;
        enable_at = -1; disable_at = -1; exp_code = 8'h00; exp_held = 1'b0;
        #1;
        check_reset_outputs(tag);
        step();
        reset_n = 1'b1;
        enable_at = cyc + 1;
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog no_finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, pc, np;
        logic [7:0] pcode;
        for (int c = 0; c < 4; c++) keys[c] = 4'h0;
        reset_n = 1'b1;
        kif.scan_en = 1'b0;
        kif.row_in = 4'hF;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        step(); step();
        reset_n = 1'b1;
        step(); step();

        // idle scan with no keys
        kif.scan_en = 1'b1;
        enable_at = cyc + 1;
        repeat (40) step();

        // key "5" and randomized presses
        do_key(1, 1, 30);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 9)) step();
            do_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 20)));
        end

        // key "A" twice
        do_key(0, 3, 5);
        repeat (3) step();
        do_key(0, 3, 12);

        // ghosting on column 3
        keys[3] = 4'b0101;
        repeat (48) step();
        keys[3] = 4'h0;
        repeat (4) step();

        // disable while waiting for release
        press_when_safe(2, 0);
        while (cyc < pulse_at + 3) step();
        kif.scan_en = 1'b0;
        disable_at = cyc + 1;
        step();
        for (int c = 0; c < 4; c++) keys[c] = 4'h0;
        tracking = 1'b0;
        kif.row_in = keypad();
        repeat (3) step();
        kif.scan_en = 1'b1;
        enable_at = cyc + 1;
        repeat (12) step();

        // async reset in the middle of debouncing; key stays down
        press_when_safe(3, 2);
        while (cyc < w_start + S + 2) step();
        hit_reset("rst_debounce");
        step();
        while (cyc < pulse_at + 5) step();
        release_keys();
        b = restart_at;
        while (cyc < b + 3) step();

        // contact bounce driven straight onto the rows
        free_run = 1'b1; manual = 1'b1; np = 0; pc = -1; pcode = 8'h00;
        for (int i = 0; i < 10; i++) begin
            kif.row_in = (i % 2 == 0) ? 4'b1101 : 4'b1111;
            repeat (3) begin
                step();
                if (kif.key_valid) begin np++; pc = cyc; pcode = kif.key_code_raw; end
            end
        end
        kif.row_in = 4'b1101;
        b = cyc;
        while (cyc < b + D + 8) begin
            step();
            if (kif.key_valid) begin np++; pc = cyc; pcode = kif.key_code_raw; end
        end
        check("bounce_pulses",  8'(np), 8'd1);
        check("bounce_latency", 8'((pc >= b + D + 3) && (pc <= b + D + 6)), 8'd1);
        check("bounce_row",     8'(pcode[3:0]), 8'h0D);
        check("bounce_col",     8'($countones(~pcode[7:4])), 8'd1);
        check("bounce_held",    8'(kif.key_held), 8'd1);
        kif.row_in = 4'hF;
        b = cyc;
        while (cyc < b + D + 1) step();
        check("bounce_held_late", 8'(kif.key_held), 8'd1);
        step();
        check("bounce_release",   8'(kif.key_held), 8'd0);

        // resynchronise the timeline through a reset, then one more key
        free_run = 1'b0; manual = 1'b0; tracking = 1'b0;
        kif.row_in = 4'hF;
        hit_reset("rst_resync");
        repeat (5) step();
        do_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
